fme_half_sched: RTL and testbench

- Scheduler for the half-pel interpolation engine in the fractional motion estimation path.
- Accepts a stream of integer-pel candidate centre addresses from IME and runs the engine once per candidate.
- Because the engine only restarts through its active-low reset, the scheduler drives that reset to restart it.
- Scores the 9 half-pel outputs against the current-block target pixel and reports the overall best candidate/position pair.

---
 rtl/fme_half_sched.sv | 146 ++++++++++++++
 tb/tb_fme_half_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fme_half_sched.sv
// Half-pel engine scheduler: restarts the engine per IME candidate, scores its 9 outputs
// against the target pixel and reports the best pair. `FME_SKIP_CENTER_EN skips position 4.
module fme_half_sched #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CW      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        cand_valid,
    input  logic [7:0]  cand_ind,
    input  logic        cand_last,
    output logic        cand_ready,
    input  logic [7:0]  cur_pix,
    output logic        eng_rst,
    output logic [7:0]  eng_ind_pix,
    input  logic        eng_done,
    input  logic [71:0] eng_half,
    output logic        busy,
    output logic        res_valid,
    output logic [3:0]  best_pos,
    output logic [7:0]  best_ind,
    output logic [7:0]  best_cost,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StEngRst, StRun, StEval, StNext, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   run_cnt_q;
    logic [3:0]      k_q, k_nxt;
    logic            last_q;
    logic            found_q;
    logic [8:0]      int_cost_q;
    logic [3:0]      int_pos_q;
    logic [7:0]      int_ind_q;
    logic [7:0]      cur_val;
    logic [7:0]      cost;
    logic            timeout_hit;

    always_comb begin
        cur_val     = eng_half[{k_q, 3'b000} +: 8];
        cost        = (cur_val >= cur_pix) ? (cur_val - cur_pix) : (cur_pix - cur_val);
        timeout_hit = (run_cnt_q == CW'(TIMEOUT - 1));
`ifdef FME_SKIP_CENTER_EN
        k_nxt = (k_q == 4'd3) ? 4'd5 : k_q + 4'd1;
`else
        k_nxt = k_q + 4'd1;
`endif
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:   if (start) state_d = StLoad;
                StLoad:   if (cand_valid) state_d = StEngRst;
                StEngRst: state_d = StRun;
                StRun: begin
                    if (eng_done)         state_d = StEval;
                    else if (timeout_hit) state_d = StNext;
                end
                StEval:   if (k_q == 4'd8) state_d = StNext;
                StNext:   state_d = last_q ? StDone : StLoad;
                StDone:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cand_ready  <= 1'b0;
            eng_rst     <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            eng_ind_pix <= 8'h00;
            best_pos    <= 4'hF;
            best_ind    <= 8'h00;
            best_cost   <= 8'hFF;
            timeout_err <= 1'b0;
            run_cnt_q   <= '0;
            k_q         <= 4'd0;
            last_q      <= 1'b0;
            found_q     <= 1'b0;
            int_cost_q  <= 9'h100;
            int_pos_q   <= 4'hF;
            int_ind_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            // Outputs are decoded from the state being entered so they align with state_q.
            cand_ready <= (state_d == StLoad);
            eng_rst    <= !((state_d == StIdle) || (state_d == StEngRst));
            busy       <= (state_d != StIdle);
            res_valid  <= (state_d == StDone);
            if (!abort) begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            timeout_err <= 1'b0;
                            found_q     <= 1'b0;
                            int_cost_q  <= 9'h100;
                        end
                    end
                    StLoad: begin
                        if (cand_valid) begin
                            eng_ind_pix <= cand_ind;
                            last_q      <= cand_last;
                        end
                    end
                    StEngRst: run_cnt_q <= '0;
                    StRun: begin
                        run_cnt_q <= run_cnt_q + CW'(1);
                        k_q       <= 4'd0;
                        if (!eng_done && timeout_hit) timeout_err <= 1'b1;
                    end
                    StEval: begin
                        // Strict compare keeps the earlier candidate and lower k on ties.
                        if ({1'b0, cost} < int_cost_q) begin
                            int_cost_q <= {1'b0, cost};
                            int_pos_q  <= k_q;
                            int_ind_q  <= eng_ind_pix;
                            found_q    <= 1'b1;
                        end
                        k_q <= k_nxt;
                    end
                    StNext: begin
                        if (last_q) begin
                            best_pos  <= found_q ? int_pos_q : 4'hF;
                            best_ind  <= found_q ? int_ind_q : 8'h00;
                            best_cost <= found_q ? int_cost_q[7:0] : 8'hFF;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fme_half_sched.sv
// Directed bench for fme_half_sched: vector table of whole searches plus hand-written
// abort and async-reset sequences, with a simple cycle-counting engine model.
module tb_fme_half_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, cand_valid, cand_last, cand_ready;
    logic [7:0]  cand_ind, cur_pix, eng_ind_pix;
    logic        eng_rst, eng_done, busy, res_valid, timeout_err;
    logic [71:0] eng_half;
    logic [3:0]  best_pos;
    logic [7:0]  best_ind, best_cost;

    int total = 0;
    int bad   = 0;

    fme_half_sched #(.TIMEOUT(40), .CW(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cand_valid  (cand_valid),
        .cand_ind    (cand_ind),
        .cand_last   (cand_last),
        .cand_ready  (cand_ready),
        .cur_pix     (cur_pix),
        .eng_rst     (eng_rst),
        .eng_ind_pix (eng_ind_pix),
        .eng_done    (eng_done),
        .eng_half    (eng_half),
        .busy        (busy),
        .res_valid   (res_valid),
        .best_pos    (best_pos),
        .best_ind    (best_ind),
        .best_cost   (best_cost),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Engine model: done after m_dly cycles out of reset (0 = never), results held.
    logic [7:0]  m_dly  = 8'd0;
    logic [71:0] m_half = '0;
    logic [7:0]  ecnt   = 8'd0;
    always @(posedge clk) begin
        if (!eng_rst) ecnt <= 8'd0;
        else if (ecnt != 8'hFF) ecnt <= ecnt + 8'd1;
    end
    assign eng_done = eng_rst && (m_dly != 8'd0) && (ecnt >= m_dly - 8'd1);
    assign eng_half = m_half;

    // Monitors: result pulses, engine-reset cycles, RUN length before a timeout.
    int   nres = 0, nrstlo = 0, hi_run = 0, to_run = 0, nrise = 0;
    logic terr_prev = 1'b0;
    always @(negedge clk) begin
        if (res_valid) nres <= nres + 1;
        if (busy && !eng_rst) nrstlo <= nrstlo + 1;
        if (!eng_rst) hi_run <= 0;
        else if (!timeout_err) hi_run <= hi_run + 1;
        if (timeout_err && !terr_prev) begin
            to_run <= hi_run;
            nrise  <= nrise + 1;
        end
        terr_prev <= timeout_err;
    end

    typedef struct {
        int              ncand;
        logic [7:0]      pix;
        logic [2:0][7:0] ind;
        logic [2:0][7:0] dly;
        logic [2:0][71:0] half;
        int              poke;
        logic [3:0]      e_pos;
        logic [7:0]      e_ind;
        logic [7:0]      e_cost;
        logic            e_terr;
        int              e_rise;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [71:0] h9(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7,
                                       input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int b_res, b_lo, b_rise, n;
        string s;
        s = $sformatf("v%0d", id);
        cur_pix = v.pix;
        @(negedge clk);
        b_res = nres; b_lo = nrstlo; b_rise = nrise;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < v.ncand; i++) begin
            n = 0;
            while (!cand_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk({s, "_ready_wait"}, 32'(n < 300), 32'd1);
            cand_ind   = v.ind[i];
            cand_last  = (i == v.ncand - 1);
            cand_valid = 1'b1;
            m_half     = v.half[i];
            m_dly      = v.dly[i];
            @(negedge clk);
            cand_valid = 1'b0;
            cand_last  = 1'b0;
            chk({s, "_ready_drop"}, 32'(cand_ready), 32'd0);
            if (v.poke == i) begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        n = 0;
        while (!res_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({s, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({s, "_best_pos"}, 32'(best_pos), 32'(v.e_pos));
        chk({s, "_best_ind"}, 32'(best_ind), 32'(v.e_ind));
        chk({s, "_best_cost"}, 32'(best_cost), 32'(v.e_cost));
        chk({s, "_timeout_err"}, 32'(timeout_err), 32'(v.e_terr));
        @(negedge clk);
        chk({s, "_res_pulse_end"}, 32'(res_valid), 32'd0);
        chk({s, "_idle_busy"}, 32'(busy), 32'd0);
        chk({s, "_res_count"}, 32'(nres - b_res), 32'd1);
        chk({s, "_eng_rst_cycles"}, 32'(nrstlo - b_lo), 32'(v.ncand));
        chk({s, "_timeout_rises"}, 32'(nrise - b_rise), 32'(v.e_rise));
    endtask

    initial begin
        int hold_bad, b_res, n;

        // Single candidate: costs {10,5,1,20,0,1,20,40,1}.
        vecs[0].ncand = 1; vecs[0].pix = 8'd100; vecs[0].poke = -1;
        vecs[0].ind[0] = 8'h55; vecs[0].dly[0] = 8'd28;
        vecs[0].half[0] = h9(90, 95, 99, 120, 100, 101, 80, 60, 99);
`ifdef FME_SKIP_CENTER_EN
        vecs[0].e_pos = 4'd2; vecs[0].e_cost = 8'd1;
`else
        vecs[0].e_pos = 4'd4; vecs[0].e_cost = 8'd0;
`endif
        vecs[0].e_ind = 8'h55; vecs[0].e_terr = 1'b0; vecs[0].e_rise = 0;

        // Tie at cost 3: first candidate k=7, third candidate k=1.
        vecs[1].ncand = 3; vecs[1].pix = 8'd100; vecs[1].poke = -1;
        vecs[1].ind[0] = 8'h10; vecs[1].dly[0] = 8'd28;
        vecs[1].half[0] = h9(0, 0, 0, 0, 0, 0, 0, 103, 0);
        vecs[1].ind[1] = 8'h20; vecs[1].dly[1] = 8'd5;
        vecs[1].half[1] = h9(90, 90, 90, 90, 90, 90, 90, 90, 90);
        vecs[1].ind[2] = 8'h30; vecs[1].dly[2] = 8'd28;
        vecs[1].half[2] = h9(0, 97, 0, 0, 0, 0, 0, 0, 0);
        vecs[1].e_pos = 4'd7; vecs[1].e_ind = 8'h10; vecs[1].e_cost = 8'd3;
        vecs[1].e_terr = 1'b0; vecs[1].e_rise = 0;

        // Middle candidate never finishes (its cost-0 data must be ignored); start poked mid-run.
        vecs[2].ncand = 3; vecs[2].pix = 8'd50; vecs[2].poke = 2;
        vecs[2].ind[0] = 8'h01; vecs[2].dly[0] = 8'd28;
        vecs[2].half[0] = h9(60, 60, 60, 45, 60, 60, 60, 60, 60);
        vecs[2].ind[1] = 8'h02; vecs[2].dly[1] = 8'd0;
        vecs[2].half[1] = h9(50, 50, 50, 50, 50, 50, 50, 50, 50);
        vecs[2].ind[2] = 8'h03; vecs[2].dly[2] = 8'd10;
        vecs[2].half[2] = h9(0, 0, 0, 0, 0, 0, 52, 0, 0);
        vecs[2].e_pos = 4'd6; vecs[2].e_ind = 8'h03; vecs[2].e_cost = 8'd2;
        vecs[2].e_terr = 1'b1; vecs[2].e_rise = 1;

        // Every candidate times out.
        vecs[3].ncand = 2; vecs[3].pix = 8'd20; vecs[3].poke = -1;
        vecs[3].ind[0] = 8'hA0; vecs[3].dly[0] = 8'd0;
        vecs[3].half[0] = h9(20, 20, 20, 20, 20, 20, 20, 20, 20);
        vecs[3].ind[1] = 8'hA1; vecs[3].dly[1] = 8'd0;
        vecs[3].half[1] = h9(20, 20, 20, 20, 20, 20, 20, 20, 20);
        vecs[3].ind[2] = 8'h00; vecs[3].dly[2] = 8'd0; vecs[3].half[2] = '0;
        vecs[3].e_pos = 4'hF; vecs[3].e_ind = 8'h00; vecs[3].e_cost = 8'hFF;
        vecs[3].e_terr = 1'b1; vecs[3].e_rise = 1;

        rst = 1'b0; start = 1'b0; abort = 1'b0; cand_valid = 1'b0; cand_last = 1'b0;
        cand_ind = 8'h00; cur_pix = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_eng_rst", 32'(eng_rst), 32'd0);
        chk("rst_cand_ready", 32'(cand_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_best_pos", 32'(best_pos), 32'hF);
        chk("rst_best_cost", 32'(best_cost), 32'hFF);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
        chk("timeout_run_cycles", 32'(to_run), 32'd40);

        // Withheld candidate, then abort during RUN.
        b_res = nres;
        cur_pix = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold_bad = 0;
        for (int j = 0; j < 10; j++) begin
            if (!cand_ready) hold_bad++;
            @(negedge clk);
        end
        chk("load_ready_hold", 32'(hold_bad), 32'd0);
        cand_ind = 8'h77; cand_last = 1'b1; cand_valid = 1'b1;
        m_half = '0; m_dly = 8'd0;
        @(negedge clk);
        cand_valid = 1'b0; cand_last = 1'b0;
        repeat (6) @(negedge clk);
        chk("run_ready_low", 32'(cand_ready), 32'd0);
        chk("run_eng_rst", 32'(eng_rst), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_eng_rst", 32'(eng_rst), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_no_res", 32'(nres - b_res), 32'd0);
        chk("abort_keep_pos", 32'(best_pos), 32'hF);
        chk("abort_keep_cost", 32'(best_cost), 32'hFF);
        chk("abort_terr", 32'(timeout_err), 32'd0);
        run_vec(vecs[0], 4);

        // Async reset in the middle of EVAL, after an ignored start.
        cur_pix = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cand_ind = 8'h55; cand_last = 1'b1; cand_valid = 1'b1;
        m_half = vecs[0].half[0]; m_dly = 8'd28;
        @(negedge clk);
        cand_valid = 1'b0; cand_last = 1'b0;
        n = 0;
        while (!eng_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("eval_reached", 32'(eng_done), 32'd1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_eng_rst", 32'(eng_rst), 32'd0);
        chk("arst_eng_ind", 32'(eng_ind_pix), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_best_pos", 32'(best_pos), 32'hF);
        chk("arst_best_ind", 32'(best_ind), 32'd0);
        chk("arst_best_cost", 32'(best_cost), 32'hFF);
        chk("arst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[1], 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
